// File: rtl/rom_stream_pkg.sv
// rom_stream_pkg: shared types and constants for the ROM readback streamer
package rom_stream_pkg;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, FINISH} state_t;
  localparam int WORD_BYTES = 4;
  localparam int unsigned DEF_MAX_BYTES = 32'h8000;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/stream_skid_fifo.sv
// stream_skid_fifo: small synchronous FIFO that parks returned ROM words until the pipe-out FIFO accepts them
module stream_skid_fifo
  import rom_stream_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int W     = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        wr_en_i,
  input  logic [W-1:0]                din_i,
  input  logic                        rd_en_i,
  output logic [W-1:0]                dout_o,
  output logic [clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = clog2(DEPTH);
  localparam int CW = clog2(DEPTH + 1);
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wp_q, rp_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en_i) wp_q <= nxt(wp_q);
      if (rd_en_i) rp_q <= nxt(rp_q);
      cnt_q <= cnt_q + CW'(wr_en_i) - CW'(rd_en_i);
    end
  always_ff @(posedge clk_i)
    if (wr_en_i) mem_q[wp_q] <= din_i;
  assign dout_o  = (cnt_q == '0) ? '0 : mem_q[rp_q];
  assign count_o = cnt_q;
endmodule

// File: rtl/rom_readback_streamer.sv
// rom_readback_streamer: credit-controlled reader that streams a ROM byte range into the pipe-out FIFO
module rom_readback_streamer
  import rom_stream_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          RD_LAT    = 1,
  parameter int unsigned MAX_BYTES = DEF_MAX_BYTES
) (
  input  logic              core_clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              abort_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] byte_len_i,
  output logic              rom_en_o,
  output logic [ADDR_W-1:0] rom_addr_o,
  input  logic [31:0]       rom_dout_i,
  output logic [31:0]       fifo_din_o,
  output logic              fifo_wr_en_o,
  input  logic              fifo_full_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [ADDR_W-1:0] words_sent_o,
  output logic              clipped_o
);
  localparam int                CW      = clog2(RD_LAT + 2);
  localparam logic [CW-1:0]     CREDITS = CW'(RD_LAT + 1);
  localparam logic [ADDR_W-1:0] MAXB    = ADDR_W'(MAX_BYTES);
  localparam logic [ADDR_W-1:0] STEP    = ADDR_W'(WORD_BYTES);
  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, rem_q, rem_d, sent_q, sent_d;
  logic                clip_q, clip_d;
  logic [CW-1:0]       cred_q, cred_d, cnt;
  logic [RD_LAT-1:0]   vld_q, vld_d;
  logic [ADDR_W-1:0]   start_addr, req_words, room_words, start_words;
  logic                start_clip, accept, issue, wr_en, drained;
  assign start_addr  = base_addr_i & ~ADDR_W'(3);
  assign req_words   = (byte_len_i >> 2) + ADDR_W'(|byte_len_i[1:0]);
  assign room_words  = (start_addr >= MAXB) ? '0 : (MAXB - start_addr) >> 2;
  assign start_clip  = start_addr >= MAXB || req_words > room_words;
  assign start_words = start_clip ? room_words : req_words;
  assign accept      = state_q == IDLE && start_i;
  assign wr_en       = cnt != '0 && !fifo_full_i;
  // Done must land one cycle after the final write, so the drain check looks at post-edge occupancy
  assign drained     = vld_q == '0 && (cnt == '0 || (cnt == CW'(1) && wr_en));
  always_ff @(posedge core_clk_i or posedge reset_i)
    if (reset_i) state_q <= IDLE;
    else state_q <= state_d;
  // Zero-length requests pass through DRAIN so done lands two cycles after start
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start_i) state_d = (start_words == '0) ? DRAIN : ISSUE;
      ISSUE:   if (rem_q == '0 || abort_i) state_d = drained ? FINISH : DRAIN;
      DRAIN:   if (drained) state_d = FINISH;
      default: state_d = IDLE;
    endcase
  end
  // A word leaving the skid buffer this cycle frees a slot in time for a new issue
  always_comb begin
    issue      = state_q == ISSUE && rem_q != '0 && !abort_i && (cred_q != '0 || wr_en);
    rom_en_o   = issue;
    rom_addr_o = issue ? addr_q : '0;
    busy_o     = state_q != IDLE;
    done_o     = state_q == FINISH;
  end
  always_comb begin
    addr_d = accept ? start_addr : addr_q + (issue ? STEP : '0);
    rem_d  = accept ? start_words : rem_q - ADDR_W'(issue);
    sent_d = accept ? '0 : sent_q + ADDR_W'(wr_en);
    clip_d = accept ? start_clip : clip_q;
    cred_d = cred_q - CW'(issue) + CW'(wr_en);
    vld_d  = RD_LAT'({vld_q, issue});
  end
  always_ff @(posedge core_clk_i or posedge reset_i)
    if (reset_i) begin
      addr_q <= '0;
      rem_q  <= '0;
      sent_q <= '0;
      clip_q <= 1'b0;
      cred_q <= CREDITS;
      vld_q  <= '0;
    end else begin
      addr_q <= addr_d;
      rem_q  <= rem_d;
      sent_q <= sent_d;
      clip_q <= clip_d;
      cred_q <= cred_d;
      vld_q  <= vld_d;
    end
  stream_skid_fifo #(.DEPTH(RD_LAT + 1), .W(32)) u_skid (
    .clk_i   (core_clk_i),
    .rst_i   (reset_i),
    .wr_en_i (vld_q[RD_LAT-1]),
    .din_i   (rom_dout_i),
    .rd_en_i (wr_en),
    .dout_o  (fifo_din_o),
    .count_o (cnt)
  );
  assign fifo_wr_en_o = wr_en;
  assign words_sent_o = sent_q;
  assign clipped_o    = clip_q;
endmodule
